// File: rtl/controlador_botoes_n.sv
// -----------------------------------------------------------------------------
// controlador_botoes_n
// N-channel button front end: per channel a 2-flop synchroniser, symmetric
// press/release debouncer, one-cycle press pulse, one-cycle long-press pulse
// and optional auto-repeat pulses while the button stays held.
//
// Ports
//   clk      : system clock, all logic on the rising edge
//   rst_n    : asynchronous active-low reset
//   b_in     : raw asynchronous button levels (N_BOTOES bits)
//   b_level  : debounced state per channel, 1 = pressed
//   b_pulse  : one-cycle pulse on debounced press and on each auto-repeat
//   b_long   : one-cycle pulse when the hold reaches HOLD_CYCLES
// -----------------------------------------------------------------------------
module controlador_botoes_n #(
    parameter int N_BOTOES      = 3,
    parameter bit ATIVO_BAIXO   = 1'b1,
    parameter int DEBOUNCE      = 16,
    parameter int HOLD_CYCLES   = 50000000,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int REPEAT_CYCLES = 12500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_BOTOES-1:0] b_in,
    output logic [N_BOTOES-1:0] b_level,
    output logic [N_BOTOES-1:0] b_pulse,
    output logic [N_BOTOES-1:0] b_long
);

    localparam int DB_W   = (DEBOUNCE > 1)      ? $clog2(DEBOUNCE)      : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1)   ? $clog2(HOLD_CYCLES)   : 1;
    localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_CYCLES - 1);

    // Raw level of a released button
    localparam logic IDLE_RAW = ATIVO_BAIXO;

    typedef enum logic [1:0] {
        SOLTO       = 2'd0,
        PRESSIONADO = 2'd1,
        SEGURADO    = 2'd2
    } estado_t;

    logic [N_BOTOES-1:0] sync1_r;
    logic [N_BOTOES-1:0] sync2_r;
    logic [N_BOTOES-1:0] s_s;

    // Two-flop synchroniser; resets to the released raw level so no phantom press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {N_BOTOES{IDLE_RAW}};
            sync2_r <= {N_BOTOES{IDLE_RAW}};
        end else begin
            sync1_r <= b_in;
            sync2_r <= sync1_r;
        end
    end

    // Normalise polarity: s = 1 means pressed
    assign s_s = sync2_r ^ {N_BOTOES{ATIVO_BAIXO}};

    for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
        logic [DB_W-1:0]   db_cnt_r;
        logic [DB_W-1:0]   db_cnt_nxt_s;
        logic              nivel_r;
        logic              nivel_nxt_s;
        logic              aperto_s;
        logic              solta_s;
        estado_t           estado_r;
        estado_t           estado_nxt_s;
        logic [HOLD_W-1:0] hold_cnt_r;
        logic [HOLD_W-1:0] hold_cnt_nxt_s;
        logic [REP_W-1:0]  rep_cnt_r;
        logic [REP_W-1:0]  rep_cnt_nxt_s;
        logic              pulse_nxt_s;
        logic              long_nxt_s;
        logic              pulse_r;
        logic              long_r;

        // Debounce: count consecutive mismatches, adopt the new level on the last one
        always_comb begin
            db_cnt_nxt_s = db_cnt_r;
            nivel_nxt_s  = nivel_r;
            if (s_s[i] == nivel_r) begin
                db_cnt_nxt_s = {DB_W{1'b0}};
            end else if (db_cnt_r == DB_MAX) begin
                db_cnt_nxt_s = {DB_W{1'b0}};
                nivel_nxt_s  = s_s[i];
            end else begin
                db_cnt_nxt_s = db_cnt_r + DB_W'(1);
            end
        end

        assign aperto_s = nivel_nxt_s & ~nivel_r;
        assign solta_s  = ~nivel_nxt_s & nivel_r;

        // Debounce counter and debounced level registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt_r <= {DB_W{1'b0}};
                nivel_r  <= 1'b0;
            end else begin
                db_cnt_r <= db_cnt_nxt_s;
                nivel_r  <= nivel_nxt_s;
            end
        end

        // FSM state and its hold/repeat counters
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                estado_r   <= SOLTO;
                hold_cnt_r <= {HOLD_W{1'b0}};
                rep_cnt_r  <= {REP_W{1'b0}};
            end else begin
                estado_r   <= estado_nxt_s;
                hold_cnt_r <= hold_cnt_nxt_s;
                rep_cnt_r  <= rep_cnt_nxt_s;
            end
        end

        // Next-state logic; release wins over any hold/repeat event in the same cycle
        always_comb begin
            estado_nxt_s   = estado_r;
            hold_cnt_nxt_s = hold_cnt_r;
            rep_cnt_nxt_s  = rep_cnt_r;
            case (estado_r)
                SOLTO: begin
                    if (aperto_s) begin
                        estado_nxt_s   = PRESSIONADO;
                        hold_cnt_nxt_s = {HOLD_W{1'b0}};
                    end else begin
                        estado_nxt_s   = SOLTO;
                    end
                end
                PRESSIONADO: begin
                    if (solta_s) begin
                        estado_nxt_s   = SOLTO;
                        hold_cnt_nxt_s = {HOLD_W{1'b0}};
                        rep_cnt_nxt_s  = {REP_W{1'b0}};
                    end else if (hold_cnt_r == HOLD_MAX) begin
                        // hold counter parks here until release
                        estado_nxt_s   = SEGURADO;
                        rep_cnt_nxt_s  = {REP_W{1'b0}};
                    end else begin
                        hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
                    end
                end
                SEGURADO: begin
                    if (solta_s) begin
                        estado_nxt_s   = SOLTO;
                        hold_cnt_nxt_s = {HOLD_W{1'b0}};
                        rep_cnt_nxt_s  = {REP_W{1'b0}};
                    end else if (REPEAT_EN) begin
                        if (rep_cnt_r == REP_MAX) begin
                            rep_cnt_nxt_s = {REP_W{1'b0}};
                        end else begin
                            rep_cnt_nxt_s = rep_cnt_r + REP_W'(1);
                        end
                    end else begin
                        estado_nxt_s = SEGURADO;
                    end
                end
                default: begin
                    estado_nxt_s   = SOLTO;
                    hold_cnt_nxt_s = {HOLD_W{1'b0}};
                    rep_cnt_nxt_s  = {REP_W{1'b0}};
                end
            endcase
        end

        // Output decode; press/repeat and long events live in different states so never coincide
        always_comb begin
            pulse_nxt_s = 1'b0;
            long_nxt_s  = 1'b0;
            case (estado_r)
                SOLTO: begin
                    pulse_nxt_s = aperto_s;
                end
                PRESSIONADO: begin
                    long_nxt_s = ~solta_s & (hold_cnt_r == HOLD_MAX);
                end
                SEGURADO: begin
                    pulse_nxt_s = REPEAT_EN & ~solta_s & (rep_cnt_r == REP_MAX);
                end
                default: begin
                    pulse_nxt_s = 1'b0;
                    long_nxt_s  = 1'b0;
                end
            endcase
        end

        // Registered pulse outputs
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pulse_r <= 1'b0;
                long_r  <= 1'b0;
            end else begin
                pulse_r <= pulse_nxt_s;
                long_r  <= long_nxt_s;
            end
        end

        assign b_level[i] = nivel_r;
        assign b_pulse[i] = pulse_r;
        assign b_long[i]  = long_r;
    end

endmodule

// File: tb/tb_controlador_botoes_n.sv
// -----------------------------------------------------------------------------
// tb_controlador_botoes_n
// Two instances (auto-repeat on / off) driven with directed scenarios and
// random press/bounce/reset traffic. A timestamp-based reference model predicts
// every output each cycle; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_controlador_botoes_n;

    localparam int N    = 3;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] b_in_a, b_in_b;
    logic [N-1:0] lvl_a, pul_a, lng_a;
    logic [N-1:0] lvl_b, pul_b, lng_b;
    logic [N-1:0] press_a, press_b;

    always #5 clk = ~clk;

    controlador_botoes_n #(
        .N_BOTOES(N), .ATIVO_BAIXO(1'b1), .DEBOUNCE(DB),
        .HOLD_CYCLES(HOLD), .REPEAT_EN(1'b1), .REPEAT_CYCLES(REP)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .b_in(b_in_a),
        .b_level(lvl_a), .b_pulse(pul_a), .b_long(lng_a)
    );

    controlador_botoes_n #(
        .N_BOTOES(N), .ATIVO_BAIXO(1'b1), .DEBOUNCE(DB),
        .HOLD_CYCLES(HOLD), .REPEAT_EN(1'b0), .REPEAT_CYCLES(REP)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .b_in(b_in_b),
        .b_level(lvl_b), .b_pulse(pul_b), .b_long(lng_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Debounced level flips once DB consecutive synchronised samples disagree
    // with it; long/repeat events are timestamps relative to the press.
    int           ciclo = 0;
    logic         m_ff1   [2][N];
    logic         m_ff2   [2][N];
    logic         m_lvl   [2][N];
    logic         run_val [2][N];
    int           run_len [2][N];
    int           t_press [2][N];
    logic [N-1:0] exp_lvl [2];
    logic [N-1:0] exp_pul [2];
    logic [N-1:0] exp_lng [2];
    logic         s_m, raw_m, antes_m;
    int           el_m;

    task automatic modelo_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                m_ff1[d][i]   = 1'b1;
                m_ff2[d][i]   = 1'b1;
                m_lvl[d][i]   = 1'b0;
                run_val[d][i] = 1'b0;
                run_len[d][i] = 0;
                t_press[d][i] = 0;
            end
            exp_lvl[d] = '0;
            exp_pul[d] = '0;
            exp_lng[d] = '0;
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            ciclo++;
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < N; i++) begin
                    raw_m = (d == 0) ? b_in_a[i] : b_in_b[i];
                    s_m   = ~m_ff2[d][i];
                    m_ff2[d][i] = m_ff1[d][i];
                    m_ff1[d][i] = raw_m;
                    if (run_len[d][i] > 0 && s_m == run_val[d][i]) begin
                        if (run_len[d][i] < DB) run_len[d][i]++;
                    end else begin
                        run_val[d][i] = s_m;
                        run_len[d][i] = 1;
                    end
                    antes_m = m_lvl[d][i];
                    if (run_len[d][i] >= DB && run_val[d][i] != m_lvl[d][i])
                        m_lvl[d][i] = run_val[d][i];
                    exp_pul[d][i] = 1'b0;
                    exp_lng[d][i] = 1'b0;
                    if (!antes_m && m_lvl[d][i]) begin
                        t_press[d][i] = ciclo;
                        exp_pul[d][i] = 1'b1;
                    end else if (antes_m && m_lvl[d][i]) begin
                        el_m = ciclo - t_press[d][i];
                        if (el_m == HOLD)
                            exp_lng[d][i] = 1'b1;
                        else if (d == 0 && el_m > HOLD && ((el_m - HOLD) % REP) == 0)
                            exp_pul[d][i] = 1'b1;
                    end
                    exp_lvl[d][i] = m_lvl[d][i];
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic confere();
        verifica("a.b_level", 32'(lvl_a), 32'(exp_lvl[0]));
        verifica("a.b_pulse", 32'(pul_a), 32'(exp_pul[0]));
        verifica("a.b_long",  32'(lng_a), 32'(exp_lng[0]));
        verifica("b.b_level", 32'(lvl_b), 32'(exp_lvl[1]));
        verifica("b.b_pulse", 32'(pul_b), 32'(exp_pul[1]));
        verifica("b.b_long",  32'(lng_b), 32'(exp_lng[1]));
    endtask

    task automatic passo();
        @(negedge clk);
        confere();
        b_in_a = ~press_a;
        b_in_b = ~press_b;
    endtask

    task automatic segura(input int n);
        repeat (n) passo();
    endtask

    task automatic aplica_reset(input int ciclos);
        @(negedge clk);
        confere();
        b_in_a = ~press_a;
        b_in_b = ~press_b;
        rst_n = 1'b0;
        modelo_reset();
        #1;
        verifica("reset.async_level", 32'({lvl_a, lvl_b}), 32'd0);
        verifica("reset.async_pulse", 32'({pul_a, pul_b, lng_a, lng_b}), 32'd0);
        repeat (ciclos) passo();
        @(negedge clk);
        confere();
        rst_n = 1'b1;
    endtask

    int           dur [2][N];
    logic [8:0]   bounce;

    initial begin
        rst_n   = 1'b0;
        press_a = '0;
        press_b = '0;
        b_in_a  = '1;
        b_in_b  = '1;
        modelo_reset();

        // 1: idle after reset, then reset asserted with ch0 pressed
        segura(3);
        @(negedge clk);
        confere();
        rst_n = 1'b1;
        segura(50);
        press_a = 3'b001;
        aplica_reset(4);

        // 2: clean press from edge 1 after release, then release
        segura(9);
        press_a = 3'b000;
        segura(20);

        // 3: bounce on ch1 (pressed-sense 1,1,1,0,1,1,0,0,0), then a 3-cycle glitch mid-press
        bounce = 9'b000110111;
        for (int k = 0; k < 9; k++) begin
            press_a[1] = bounce[k];
            passo();
        end
        segura(10);
        press_a[1] = 1'b1; segura(15);
        press_a[1] = 1'b0; segura(3);
        press_a[1] = 1'b1; segura(10);
        press_a[1] = 1'b0; segura(15);

        // 4: long hold on ch2 with auto-repeat
        press_a[2] = 1'b1; segura(66);
        press_a[2] = 1'b0; segura(15);

        // 5: simultaneous press of ch0/ch1, repeat disabled on instance b
        press_a = 3'b011; press_b = 3'b011; segura(60);
        press_a = 3'b000; press_b = 3'b000; segura(15);

        // 6: reset mid-hold with buttons still pressed
        press_a = 3'b001; press_b = 3'b001; segura(16);
        aplica_reset(3);
        segura(40);
        press_a = 3'b000; press_b = 3'b000; segura(15);

        // random traffic: glitches, presses, long holds, occasional reset
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++) dur[d][i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < N; i++) begin
                    if (dur[d][i] == 0) begin
                        if (d == 0) press_a[i] = ~press_a[i];
                        else        press_b[i] = ~press_b[i];
                        case ($urandom_range(0, 2))
                            0:       dur[d][i] = $urandom_range(1, 3);
                            1:       dur[d][i] = $urandom_range(4, 12);
                            default: dur[d][i] = $urandom_range(20, 70);
                        endcase
                    end else begin
                        dur[d][i]--;
                    end
                end
            end
            if ($urandom_range(0, 599) == 0) aplica_reset(2);
            else                              passo();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
